// File: rtl/pwm_generator.sv
// Prescaled 255-tick PWM driver for one motor H-bridge channel.
// Duty and direction change only at period boundaries; a reversal inserts zero-duty dead-time periods.
module pwm_generator #(
  parameter int unsigned PRESCALE         = 4,
  parameter int unsigned DEADTIME_PERIODS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  output logic       pwm_out,
  output logic       dir_out,
  output logic [7:0] active_ratio,
  output logic       period_start,
  output logic       busy_reverse
);

  localparam int unsigned PRESC_W   = 8;
  localparam int unsigned TICK_W    = 8;
  localparam int unsigned DEAD_W    = 4;
  localparam int unsigned RATIO_W   = 8;
  localparam int unsigned LAST_TICK = 254;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DEADTIME = 2'd2
  } state_t;

  state_t               state;
  state_t               state_d;
  logic [PRESC_W-1:0]   prescaler;
  logic [PRESC_W-1:0]   prescaler_d;
  logic [TICK_W-1:0]    tick_cnt;
  logic [TICK_W-1:0]    tick_cnt_d;
  logic [DEAD_W-1:0]    dead_cnt;
  logic [DEAD_W-1:0]    dead_cnt_d;
  logic [RATIO_W-1:0]   active_ratio_d;
  logic                 pwm_out_d;
  logic                 dir_out_d;
  logic                 period_start_d;
  logic                 busy_reverse_d;

  logic tick;
  logic boundary;
  logic dir_match;
  logic dead_last;

  assign tick      = (prescaler == PRESC_W'(PRESCALE - 1));
  assign boundary  = tick && (tick_cnt == TICK_W'(LAST_TICK));
  assign dir_match = (pwm_direction == dir_out);
  assign dead_last = (dead_cnt == DEAD_W'(DEADTIME_PERIODS - 1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; dropping enable wins from any state
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (boundary && !dir_match) state_d = DEADTIME;
      end
      DEADTIME: begin
        if (boundary && dead_last) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // Output and counter next values
  always_comb begin
    pwm_out_d      = 1'b0;
    dir_out_d      = dir_out;
    active_ratio_d = active_ratio;
    period_start_d = 1'b0;
    busy_reverse_d = busy_reverse;
    dead_cnt_d     = dead_cnt;
    prescaler_d    = '0;
    tick_cnt_d     = '0;

    if (state != IDLE) begin
      if (tick) begin
        tick_cnt_d = boundary ? '0 : tick_cnt + TICK_W'(1);
      end else begin
        prescaler_d = prescaler + PRESC_W'(1);
        tick_cnt_d  = tick_cnt;
      end
    end

    case (state)
      IDLE: begin
        active_ratio_d = '0;
        busy_reverse_d = 1'b0;
        dead_cnt_d     = '0;
        if (enable) begin
          // Start-up loads direction directly, no dead-time needed
          dir_out_d      = pwm_direction;
          active_ratio_d = pwm_ratio;
          period_start_d = 1'b1;
        end
      end
      RUN: begin
        pwm_out_d = (tick_cnt < active_ratio);
        if (boundary) begin
          period_start_d = 1'b1;
          if (dir_match) begin
            active_ratio_d = pwm_ratio;
          end else begin
            active_ratio_d = '0;
            dead_cnt_d     = '0;
            busy_reverse_d = 1'b1;
          end
        end
      end
      DEADTIME: begin
        if (boundary) begin
          period_start_d = 1'b1;
          if (dead_last) begin
            dir_out_d      = pwm_direction;
            active_ratio_d = pwm_ratio;
            busy_reverse_d = 1'b0;
          end else begin
            dead_cnt_d = dead_cnt + DEAD_W'(1);
          end
        end
      end
      default: begin
        active_ratio_d = '0;
        busy_reverse_d = 1'b0;
      end
    endcase

    if (!enable) begin
      pwm_out_d      = 1'b0;
      active_ratio_d = '0;
      period_start_d = 1'b0;
      busy_reverse_d = 1'b0;
      dead_cnt_d     = '0;
      prescaler_d    = '0;
      tick_cnt_d     = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler    <= '0;
      tick_cnt     <= '0;
      dead_cnt     <= '0;
      pwm_out      <= 1'b0;
      dir_out      <= 1'b0;
      active_ratio <= '0;
      period_start <= 1'b0;
      busy_reverse <= 1'b0;
    end else begin
      prescaler    <= prescaler_d;
      tick_cnt     <= tick_cnt_d;
      dead_cnt     <= dead_cnt_d;
      pwm_out      <= pwm_out_d;
      dir_out      <= dir_out_d;
      active_ratio <= active_ratio_d;
      period_start <= period_start_d;
      busy_reverse <= busy_reverse_d;
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: duty table, directed boundary scenarios and a
// randomized run compared every clock against a period-position reference model.
module tb_pwm_generator;

  localparam int PRESCALE = 4;
  localparam int DT       = 2;
  localparam int PER      = 255 * PRESCALE;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] pwm_ratio = 8'd0;
  logic       pwm_direction = 1'b0;
  logic       pwm_out;
  logic       dir_out;
  logic [7:0] active_ratio;
  logic       period_start;
  logic       busy_reverse;

  pwm_generator #(.PRESCALE(PRESCALE), .DEADTIME_PERIODS(DT)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .pwm_ratio    (pwm_ratio),
    .pwm_direction(pwm_direction),
    .pwm_out      (pwm_out),
    .dir_out      (dir_out),
    .active_ratio (active_ratio),
    .period_start (period_start),
    .busy_reverse (busy_reverse)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endfunction

  // Reference model: position within the period in clocks, dead-time as periods remaining
  bit       m_valid = 0;
  int       m_mode  = 0;   // 0 idle, 1 run, 2 dead-time
  int       m_pos   = 0;
  int       m_dead_left = 0;
  bit       e_pwm = 0, e_dir = 0, e_ps = 0, e_busy = 0;
  bit [7:0] e_ratio = 0;

  always @(posedge clock) begin
    if (reset) begin
      m_valid = 1; m_mode = 0; m_pos = 0; m_dead_left = 0;
      e_pwm = 0; e_dir = 0; e_ratio = 0; e_ps = 0; e_busy = 0;
    end else if (!enable) begin
      m_mode = 0; m_pos = 0; m_dead_left = 0;
      e_pwm = 0; e_ratio = 0; e_ps = 0; e_busy = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_pos = 0;
      e_pwm = 0; e_dir = pwm_direction; e_ratio = pwm_ratio; e_ps = 1;
    end else begin
      e_pwm = (m_mode == 1) && ((m_pos / PRESCALE) < int'(e_ratio));
      e_ps  = (m_pos == PER - 1);
      if (e_ps) begin
        m_pos = 0;
        if (m_mode == 1) begin
          if (pwm_direction == e_dir) e_ratio = pwm_ratio;
          else begin m_mode = 2; m_dead_left = DT; e_ratio = 0; e_busy = 1; end
        end else begin
          m_dead_left--;
          if (m_dead_left == 0) begin
            m_mode = 1; e_dir = pwm_direction; e_ratio = pwm_ratio; e_busy = 0;
          end
        end
      end else begin
        m_pos++;
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid)
      check("model_outputs",
            int'({pwm_out, dir_out, active_ratio, period_start, busy_reverse}),
            int'({e_pwm, e_dir, e_ratio, e_ps, e_busy}));
  end

  typedef struct {
    logic [7:0] ratio;
    logic       dir;
    int         exp_high;
  } vec_t;

  vec_t tbl[7];

  // Called just after a negedge; returns at a negedge with reset released and enable low
  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Starting at a period_start sample, observe one full period of samples
  task automatic measure(input int chg_at, input logic [7:0] c_ratio, input logic c_dir,
                         output int high, output int busy, output int ps_pos);
    high = 0; busy = 0; ps_pos = -1;
    for (int i = 1; i <= PER; i++) begin
      @(negedge clock);
      high += int'(pwm_out);
      busy += int'(busy_reverse);
      if (period_start && ps_pos < 0) ps_pos = i;
      if (i == chg_at) begin pwm_ratio = c_ratio; pwm_direction = c_dir; end
    end
  endtask

  task automatic start_run(input logic [7:0] r, input logic d);
    pwm_ratio = r;
    pwm_direction = d;
    enable = 1'b1;
    @(negedge clock);
  endtask

  int hi, bz, pp;

  initial begin
    tbl[0] = '{8'd0,   1'b0, 0};
    tbl[1] = '{8'd1,   1'b1, 4};
    tbl[2] = '{8'd64,  1'b0, 256};
    tbl[3] = '{8'd128, 1'b1, 512};
    tbl[4] = '{8'd200, 1'b0, 800};
    tbl[5] = '{8'd254, 1'b1, 1016};
    tbl[6] = '{8'd255, 1'b0, 1020};

    @(negedge clock);
    do_reset();
    @(negedge clock);
    check("reset_outputs", int'({pwm_out, dir_out, active_ratio, period_start, busy_reverse}), 0);

    // Steady duty table: each entry starts fresh from reset
    foreach (tbl[k]) begin
      do_reset();
      start_run(tbl[k].ratio, tbl[k].dir);
      check("tbl_first_period_start", int'(period_start), 1);
      check("tbl_dir_out", int'(dir_out), int'(tbl[k].dir));
      check("tbl_active_ratio", int'(active_ratio), int'(tbl[k].ratio));
      measure(-1, 8'd0, 1'b0, hi, bz, pp);
      check("tbl_high_clocks", hi, tbl[k].exp_high);
      check("tbl_period_len", pp, PER);
    end

    // Ratio zero stays low for three periods
    do_reset();
    start_run(8'd0, 1'b1);
    for (int p = 0; p < 3; p++) begin
      measure(-1, 8'd0, 1'b1, hi, bz, pp);
      check("ratio0_high", hi, 0);
      check("ratio0_period", pp, PER);
    end

    // Mid-period ratio change is deferred to the boundary
    do_reset();
    start_run(8'd64, 1'b0);
    measure(120, 8'd200, 1'b0, hi, bz, pp);
    check("defer_cur_high", hi, 256);
    check("defer_ratio_at_ps", int'(active_ratio), 200);
    measure(-1, 8'd0, 1'b0, hi, bz, pp);
    check("defer_next_high", hi, 800);

    // Direction reversal with dead-time
    do_reset();
    start_run(8'd100, 1'b1);
    measure(200, 8'd100, 1'b0, hi, bz, pp);
    check("rev_finish_high", hi, 400);
    check("rev_busy_set", int'(busy_reverse), 1);
    check("rev_dir_held", int'(dir_out), 1);
    measure(-1, 8'd0, 1'b0, hi, bz, pp);
    check("rev_dead1_high", hi, 0);
    check("rev_dead1_busy", bz, 1020);
    check("rev_dead1_dir", int'(dir_out), 1);
    pwm_ratio = 8'd100;
    measure(-1, 8'd0, 1'b0, hi, bz, pp);
    check("rev_dead2_high", hi, 0);
    check("rev_dead2_busy", bz, 1019);
    check("rev_dir_flipped", int'(dir_out), 0);
    check("rev_ratio_back", int'(active_ratio), 100);
    pwm_ratio = 8'd100;
    measure(-1, 8'd0, 1'b0, hi, bz, pp);
    check("rev_after_high", hi, 400);

    // Enable dropped in the high phase, then re-enabled
    do_reset();
    start_run(8'd128, 1'b0);
    repeat (100) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("drop_pwm_low", int'(pwm_out), 0);
    check("drop_ratio_zero", int'(active_ratio), 0);
    repeat (5) @(negedge clock);
    start_run(8'd50, 1'b0);
    check("reen_period_start", int'(period_start), 1);
    check("reen_ratio", int'(active_ratio), 50);
    measure(-1, 8'd0, 1'b0, hi, bz, pp);
    check("reen_high", hi, 200);
    check("reen_period", pp, PER);

    // Reset during dead-time
    do_reset();
    start_run(8'd80, 1'b0);
    measure(10, 8'd80, 1'b1, hi, bz, pp);
    check("rst_dead_entered", int'(busy_reverse), 1);
    repeat (300) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_dead_outputs", int'({pwm_out, dir_out, active_ratio, period_start, busy_reverse}), 0);
    pwm_ratio = 8'd128;
    reset = 1'b0;
    @(negedge clock);
    check("rst_restart_ps", int'(period_start), 1);
    check("rst_restart_dir", int'(dir_out), 1);
    measure(-1, 8'd0, 1'b1, hi, bz, pp);
    check("rst_restart_high", hi, 512);

    // Randomized run; the reference model checks every clock
    for (int c = 0; c < 20000; c++) begin
      @(negedge clock);
      reset = 1'b0;
      if ($urandom_range(0, 49) == 0) pwm_ratio = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1499) == 0) pwm_direction = ~pwm_direction;
      if ($urandom_range(0, 2999) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 199) == 0) enable = 1'b1;
      if ($urandom_range(0, 6999) == 0) reset = 1'b1;
    end
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
- Downstream consumer of the hammer-start stage's pwm_ratio / pwm_direction outputs; turns them into the physical PWM and direction pins of one motor driver.
- Free-running prescaled PWM, 255 ticks per period.
- Duty and direction updates are glitch-free: they take effect only at period boundaries.
- A direction reversal forces a dead-time of whole zero-duty periods before the direction pin flips, protecting the H-bridge.

Parameters:
- PRESCALE, 4, clocks per PWM tick; legal range 1..255.
- DEADTIME_PERIODS, 2, full zero-duty periods inserted before a direction change; legal range 1..15.

Ports:
- clock  input  1  main clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = generate PWM; 0 = output forced low, counters held
- pwm_ratio  input  8  requested duty; high ticks per period (0..255)
- pwm_direction  input  1  requested motor direction
- pwm_out  output  1  PWM pin to driver
- dir_out  output  1  direction pin to driver
- active_ratio  output  8  duty currently being applied
- period_start  output  1  one-clock pulse at the start of each period
- busy_reverse  output  1  high while in dead-time

Behaviour:
- The one clock is `clock`. Reset is synchronous and active-high on `reset`; it overrides all other inputs.
- Reset values:
  - pwm_out=0, dir_out=0, active_ratio=0, period_start=0, busy_reverse=0.
  - Prescaler=0, tick_cnt=0, dead_cnt=0, state=IDLE.
- Counters:
  - Prescaler runs 0..PRESCALE-1. A tick occurs when prescaler==PRESCALE-1.
  - tick_cnt (8 bit) advances on each tick, 0..254, then wraps to 0.
  - Period = 255*PRESCALE clocks.
- Boundary: the clock on which a tick occurs with tick_cnt==254. On the following clock tick_cnt=0 and period_start=1 for exactly that one clock.
- pwm_out is registered: pwm_out <= (state==RUN) && (tick_cnt < active_ratio), one clock of latency.
  - High time per period = active_ratio*PRESCALE clocks exactly.
  - ratio 0 gives a constant low; ratio 255 gives a constant high.
- States:
  - IDLE (enable=0):
    - Prescaler, tick_cnt and dead_cnt held at 0; active_ratio=0; pwm_out=0 on the next clock.
    - dir_out holds its last value.
    - On enable=1: dir_out<=pwm_direction, active_ratio<=pwm_ratio, prescaler and tick_cnt start from 0, period_start pulses on that same transition clock, then go to RUN.
  - RUN:
    - At each boundary, if pwm_direction==dir_out: active_ratio<=pwm_ratio, stay in RUN.
    - If they differ: active_ratio<=0, dead_cnt<=0, busy_reverse<=1, go to DEADTIME.
    - A pwm_ratio change mid-period is ignored until the next boundary.
  - DEADTIME:
    - active_ratio stays 0; dir_out is unchanged.
    - At each boundary dead_cnt increments.
    - At the boundary where dead_cnt==DEADTIME_PERIODS-1: dir_out<=pwm_direction (value sampled then), active_ratio<=pwm_ratio, busy_reverse<=0, go to RUN.
    - If pwm_direction returns to the old value during dead-time, the dead-time still completes and dir_out is simply unchanged.
- enable=0 in any state:
  - Go to IDLE on the next clock; pwm_out=0 and busy_reverse=0 on that clock.
  - An in-progress dead-time is abandoned. Re-enable then loads pwm_direction directly, with no dead-time.
- Simultaneous enable rise and direction change: no dead-time; the new direction is loaded directly.
- Reset mid-period or mid-dead-time: all outputs return to reset values on the next clock, with no partial period completed.

Test Plan:
1. PRESCALE=4, reset, then enable=1, ratio=128, dir=1 → dir_out=1 next clock; period_start every 1020 clocks; pwm_out high 512 of each 1020 clocks.
2. ratio=0 → pwm_out never high over 3 periods. ratio=255 → pwm_out continuously high from one clock after enable; period_start still pulses every 1020 clocks.
3. ratio=64, change to 200 at tick 30 → current period high 256 clocks; next period high 800 clocks; active_ratio changes exactly on the period_start clock.
4. ratio=100, dir 1→0 mid-period → current period finishes at 400-clock high. Then 2 periods with pwm_out=0, busy_reverse=1, dir_out=1. Then dir_out=0, busy_reverse=0, and high 400 clocks per period.
5. enable dropped during the high phase → pwm_out=0 next clock, active_ratio=0. Re-enable with ratio=50 → period_start on the enable clock; high 200 clocks.
6. reset asserted during DEADTIME → next clock: all outputs 0 and state IDLE. After release with enable=1, operation restarts as in scenario 1.
